// File: rtl/tile_arb_pkg.sv
// Shared widths and FSM state encodings for the tile-calculator arbiter.
package tile_arb_pkg;

    localparam int unsigned COORD_W = 128;
    localparam int unsigned IDX_W   = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ST_W    = 2;

    typedef logic [ST_W-1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/tile_calc_arbiter_rr_arbiter.sv
// Round-robin picker: first request at or after ptr, wrapping, as one-hot grant plus index.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] idx_c,
    output logic                 any_c
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any_c && req[(32'(ptr) + i) % N]) begin
                any_c = 1'b1;
                idx_c = IW'((32'(ptr) + i) % N);
            end
        end
        if (any_c) begin
            grant_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/tile_calc_arbiter.sv
// Arbitrates NUM_SRC point-batch sources onto one shared tile-index calculator.
// Optional per-source accept counters are enabled with the TILE_ARB_STATS_EN macro.
module tile_calc_arbiter
    import tile_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*COORD_W-1:0]   src_coords,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic [COORD_W-1:0]           calc_coords,
    output logic                         calc_valid,
    input  logic [IDX_W-1:0]             calc_indices,
    input  logic                         calc_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_indices,
    output logic [$clog2(NUM_SRC)-1:0]   out_src_id,
    output logic                         timeout_err
`ifdef TILE_ARB_STATS_EN
    ,
    output logic [NUM_SRC*CNT_W-1:0]     grant_cnt
`endif
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned TMO_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   rr_q, rr_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               calc_valid_d;
    logic [COORD_W-1:0] calc_coords_d;
    logic               out_valid_d;
    logic [IDX_W-1:0]   out_indices_d;
    logic [SRC_W-1:0]   out_src_id_d;
    logic               timeout_err_d;

    logic [NUM_SRC-1:0] grant_c;
    logic [SRC_W-1:0]   idx_c;
    logic               any_c;
    logic               accept_c;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req     (src_valid),
        .ptr     (rr_q),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .any_c   (any_c)
    );

    // Only the winner sees ready, and only while idle and out of reset.
    assign accept_c  = (state_q == ST_IDLE) && any_c;
    assign src_ready = (reset_n && state_q == ST_IDLE) ? grant_c : '0;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        calc_valid_d  = 1'b0;
        calc_coords_d = calc_coords;
        out_valid_d   = out_valid;
        out_indices_d = out_indices;
        out_src_id_d  = out_src_id;
        timeout_err_d = timeout_err;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    calc_coords_d = src_coords[32'(idx_c)*COORD_W +: COORD_W];
                    owner_d       = idx_c;
                    rr_d          = (idx_c == SRC_W'(NUM_SRC - 1)) ? '0 : idx_c + SRC_W'(1);
                    calc_valid_d  = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (calc_done) begin
                    out_indices_d = calc_indices;
                    out_src_id_d  = owner_q;
                    out_valid_d   = 1'b1;
                    state_d       = ST_OUT;
                end else if (cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    // Final allowed wait cycle without a result: drop the batch.
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            calc_valid  <= 1'b0;
            calc_coords <= '0;
            out_valid   <= 1'b0;
            out_indices <= '0;
            out_src_id  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            calc_valid  <= calc_valid_d;
            calc_coords <= calc_coords_d;
            out_valid   <= out_valid_d;
            out_indices <= out_indices_d;
            out_src_id  <= out_src_id_d;
            timeout_err <= timeout_err_d;
        end
    end

`ifdef TILE_ARB_STATS_EN
    // Per-source saturating accept counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt <= '0;
        end else if (accept_c) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                if (idx_c == SRC_W'(k) && grant_cnt[k*CNT_W +: CNT_W] != '1) begin
                    grant_cnt[k*CNT_W +: CNT_W] <= grant_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: doc/tile_calc_arbiter.md
TILE_CALC_ARBITER -- requirements
Module: tile_calc_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of point-source requesters (2..8).
REQ-002 Parameter TIMEOUT, default 15: max cycles waited for calculator result.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 src_valid  input  NUM_SRC  per-source request, one 4-point batch.
REQ-006 src_coords  input  NUM_SRC*128  per-source normalized coords, source k at [k*128+127:k*128].
REQ-007 src_ready  output  NUM_SRC  per-source accept; at most one bit high.
REQ-008 calc_coords  output  128  registered coords to shared tile-index calculator.
REQ-009 calc_valid  output  1  one-cycle issue strobe to calculator.
REQ-010 calc_indices  input  32  calculator result, four 8-bit {Y,X} tile indices.
REQ-011 calc_done  input  1  calculator result valid.
REQ-012 out_valid  output  1  result available downstream.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_indices  output  32  captured tile indices.
REQ-015 out_src_id  output  $clog2(NUM_SRC)  source that owns out_indices.
REQ-016 timeout_err  output  1  sticky, set on calculator timeout.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, OUT; exactly one active.
REQ-018 IDLE: round-robin winner = first src_valid bit at or after rr_ptr (wrapping NUM_SRC-1 -> 0); src_ready driven high combinationally for winner only.
REQ-019 Accept = src_valid[w] & src_ready[w]; on accept register src_coords of w into calc_coords, latch w as owner, rr_ptr <= w+1 mod NUM_SRC, go ISSUE.
REQ-020 No request in IDLE: stay IDLE, rr_ptr unchanged.
REQ-021 ISSUE: calc_valid=1 for exactly one cycle, go WAIT, clear timeout counter.
REQ-022 WAIT: on calc_done capture calc_indices into out_indices, owner into out_src_id, go OUT; otherwise increment 4-bit-minimum counter.
REQ-023 WAIT: counter reaching TIMEOUT without calc_done sets timeout_err, discards batch, returns IDLE.
REQ-024 calc_done outside WAIT is ignored.
REQ-025 OUT: out_valid=1, out_indices/out_src_id stable until out_ready; on out_ready go IDLE.
REQ-026 All src_ready low in ISSUE, WAIT, OUT (one batch in flight).
REQ-027 Minimum latency accept->out_valid: 3 cycles with a 1-cycle calculator; throughput one batch per 4 cycles when out_ready held high.
REQ-028 Source deasserting src_valid before accept loses nothing; no request is dropped once accepted except on timeout.
REQ-029 timeout_err clears only on reset.

Reset
REQ-030 reset_n low, asynchronously: state IDLE, rr_ptr 0, calc_valid 0, calc_coords 0, out_valid 0, out_indices 0, out_src_id 0, timeout_err 0, counter 0.
REQ-031 Reset mid-operation abandons in-flight batch; no out_valid produced for it after release.
REQ-032 src_ready low while reset_n low.

Configuration
REQ-033 Macro TILE_ARB_STATS_EN: when defined, adds output grant_cnt (NUM_SRC*16 bits), per-source 16-bit saturating count of accepts, reset to 0.
REQ-034 Without TILE_ARB_STATS_EN: port and counters absent; all other behaviour identical.

Structure
REQ-035 Package tile_arb_pkg holds state enum, COORD_W=128, IDX_W=32, CNT_W=16.
REQ-036 Sub-module rr_arbiter (request vector, pointer -> one-hot grant, index) instantiated once.

Verification
REQ-037 Single source 2 valid coords X=0x3C0 field -> calc_valid pulse 1 cycle after accept, out_valid 3 cycles after accept, out_src_id=2.
REQ-038 All 4 sources valid continuously, out_ready=1 -> grants order 0,1,2,3,0; each out_src_id matches.
REQ-039 calc_done never asserted -> after 15 WAIT cycles timeout_err=1, state IDLE, next request accepted.
REQ-040 out_ready low 10 cycles in OUT -> out_indices stable, all src_ready low, no new calc_valid.
REQ-041 reset_n low during WAIT, calc_done high next cycle -> no out_valid, rr_ptr=0, outputs at reset values.
REQ-042 TILE_ARB_STATS_EN defined, source 1 granted 70000 times -> grant_cnt[31:16]=0xFFFF.
